// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcode constants, issue-FSM state type and opcode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // 100..110 are reserved: the ALU answers all-ones and nothing is written back.
  function automatic logic is_illegal(input logic [2:0] op);
    return op[2] && (op != OP_LDI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Purpose  : REGS x N register file, two combinational reads, one sync write.
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile #(
  parameter  int N    = 8,
  parameter  int REGS = 4,
  localparam int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [N-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [N-1:0]  rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd
);

  logic [REGS*N-1:0] w_flat;

  genvar gi;
  for (gi = 0; gi < REGS; gi++) begin : g_entry
    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (we && (wa == AW'(gi))) begin
        r_q <= wd;
      end
    end

    assign w_flat[gi*N +: N] = r_q;
  end

  assign ra_data = w_flat[int'(ra_addr)*N +: N];
  assign rb_data = w_flat[int'(rb_addr)*N +: N];

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issue
// Purpose  : Issue/writeback stage: reads operands, drives the ALU, writes the
//            result back and returns it on a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int REGS = 4,
  localparam int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_opcode,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [N-1:0]  cmd_imm,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [N-1:0]  alu_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic [AW-1:0] rsp_rd,
  output logic          rsp_zero,
  output logic          rsp_illegal
);

  state_t        r_state;
  state_t        w_state_next;

  logic [2:0]    r_opcode;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rs2;
  logic [N-1:0]  r_imm;

  logic [N-1:0]  r_result;
  logic          r_zero;
  logic          r_illegal;

  logic          w_accept;
  logic          w_exec;
  logic          w_we;
  logic [N-1:0]  w_result_next;
  logic [N-1:0]  w_rs1_data;
  logic [N-1:0]  w_rs2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // In RESP a new command can be taken in the same edge the response retires.
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        w_state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        cmd_ready = rsp_ready;
        if (rsp_ready) begin
          w_state_next = cmd_valid ? EXEC : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_accept = cmd_valid && cmd_ready;
  assign w_exec   = (r_state == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_imm    <= '0;
    end else if (w_accept) begin
      r_opcode <= cmd_opcode;
      r_rd     <= cmd_rd;
      r_rs1    <= cmd_rs1;
      r_rs2    <= cmd_rs2;
      r_imm    <= cmd_imm;
    end
  end

  assign w_result_next = (r_opcode == OP_LDI) ? r_imm : alu_result;
  assign w_we          = w_exec && !is_illegal(r_opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else if (w_exec) begin
      r_result  <= w_result_next;
      r_zero    <= (w_result_next == '0);
      r_illegal <= is_illegal(r_opcode);
    end
  end

  alu_regfile #(
    .N    (N),
    .REGS (REGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (r_rs1),
    .ra_data (w_rs1_data),
    .rb_addr (r_rs2),
    .rb_data (w_rs2_data),
    .we      (w_we),
    .wa      (r_rd),
    .wd      (w_result_next)
  );

  // ALU operands always follow the latched fields so they never float to X.
  assign alu_a       = w_rs1_data;
  assign alu_b       = w_rs2_data;
  assign alu_opcode  = r_opcode;

  assign rsp_data    = r_result;
  assign rsp_rd      = r_rd;
  assign rsp_zero    = r_zero;
  assign rsp_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_issue
// Purpose  : Self-checking bench for alu_cmd_issue with an attached ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_rd;
  logic       rsp_zero, rsp_illegal;

  int checks = 0;
  int errors = 0;

  logic [7:0] rf_m [4];

  typedef struct {
    logic [7:0] d;
    logic [1:0] rd;
    logic       z;
    logic       il;
  } exp_t;

  always #5 clk = ~clk;

  alu_cmd_issue #(.N(8), .REGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a ^ b;
      default: return 8'hFF;
    endcase
  endfunction

  // The external combinational ALU the block drives.
  assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic model_exec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic [7:0] imm, output exp_t e);
    e.il = (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
    e.d  = (op == 3'b111) ? imm : alu_fn(op, rf_m[rs1], rf_m[rs2]);
    e.z  = (e.d == 8'h00);
    e.rd = rd;
    if (!e.il) rf_m[rd] = e.d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
  endtask

  // Issues one command from IDLE, waits for the response, retires it.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm, output exp_t o, output int lat);
    int n;
    cmd_opcode = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    o.d = '0; o.rd = '0; o.z = 1'b0; o.il = 1'b0; lat = -1;
    n = 0;
    #1;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (cmd_ready) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 2; i <= 8; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) begin lat = i; break; end
      end
      if (lat > 0) begin
        o.d = rsp_data; o.rd = rsp_rd; o.z = rsp_zero; o.il = rsp_illegal;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b0;
    cmd_opcode = 3'b111; cmd_rd = 2'd1; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 8'h55;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid cyc%0d: got %b want 0", i, rsp_valid); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready cyc%0d: got %b want 1", i, cmd_ready); end
    end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    checks++; if (rsp_rd !== 2'd0) begin errors++; $display("FAIL reset_rsp_rd: got %0d want 0", rsp_rd); end
    checks++; if (rsp_zero !== 1'b1) begin errors++; $display("FAIL reset_rsp_zero: got %b want 1", rsp_zero); end
    checks++; if (rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_rsp_illegal: got %b want 0", rsp_illegal); end
    checks++; if ({alu_opcode, alu_a, alu_b} !== 19'h0) begin errors++; $display("FAIL reset_alu_outputs: got op=%0d a=%h b=%h want 0", alu_opcode, alu_a, alu_b); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_first_exec: got rsp_valid=%b want 0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h55 || rsp_rd !== 2'd1) begin
      errors++; $display("FAIL reset_first_accept: got v=%b d=%h rd=%0d want v=1 d=55 rd=1", rsp_valid, rsp_data, rsp_rd);
    end
    model_exec(3'b111, 2'd1, 2'd0, 2'd0, 8'h55, e);
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_ldi_add();
    exp_t e, o; int lat;
    logic [7:0] want [3] = '{8'h05, 8'h03, 8'h08};
    logic [2:0] ops  [3] = '{3'b111, 3'b111, 3'b000};
    logic [1:0] rds  [3] = '{2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      do_cmd(ops[i], rds[i], 2'd1, 2'd2, want[i], o, lat);
      model_exec(ops[i], rds[i], 2'd1, 2'd2, want[i], e);
      checks++; if (lat !== 2) begin errors++; $display("FAIL ldi_add_latency%0d: got %0d want 2", i, lat); end
      checks++; if (o.d !== want[i] || o.rd !== rds[i] || o.z !== 1'b0) begin
        errors++; $display("FAIL ldi_add_rsp%0d: got d=%h rd=%0d z=%b want d=%h rd=%0d z=0", i, o.d, o.rd, o.z, want[i], rds[i]);
      end
    end
  endtask

  task automatic test_arith_boundaries();
    exp_t e, o; int lat;
    logic [2:0] ops [8] = '{3'b001, 3'b001, 3'b111, 3'b111, 3'b000, 3'b011, 3'b111, 3'b111};
    logic [1:0] rds [8] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2};
    logic [1:0] s1  [8] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    logic [1:0] s2  [8] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0};
    logic [7:0] imm [8] = '{8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hF0, 8'h3C};
    logic [7:0] want[8] = '{8'hFE, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'hF0, 8'h3C};
    for (int i = 0; i < 8; i++) begin
      do_cmd(ops[i], rds[i], s1[i], s2[i], imm[i], o, lat);
      model_exec(ops[i], rds[i], s1[i], s2[i], imm[i], e);
      checks++; if (o.d !== want[i] || o.z !== (want[i] == 8'h00) || lat !== 2) begin
        errors++; $display("FAIL arith%0d: got d=%h z=%b lat=%0d want d=%h z=%b lat=2", i, o.d, o.z, lat, want[i], want[i] == 8'h00);
      end
    end
    do_cmd(3'b010, 2'd3, 2'd1, 2'd2, 8'h00, o, lat);
    model_exec(3'b010, 2'd3, 2'd1, 2'd2, 8'h00, e);
    checks++; if (o.d !== 8'h30 || o.z !== 1'b0) begin errors++; $display("FAIL arith_and: got d=%h z=%b want 30 0", o.d, o.z); end
  endtask

  task automatic test_backpressure();
    exp_t e, o; int lat;
    do_cmd(3'b111, 2'd1, 2'd0, 2'd0, 8'h10, o, lat); model_exec(3'b111, 2'd1, 2'd0, 2'd0, 8'h10, e);
    do_cmd(3'b111, 2'd2, 2'd0, 2'd0, 8'h22, o, lat); model_exec(3'b111, 2'd2, 2'd0, 2'd0, 8'h22, e);
    cmd_opcode = 3'b000; cmd_rd = 2'd3; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2; cmd_imm = 8'h00;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    model_exec(3'b000, 2'd3, 2'd1, 2'd2, 8'h00, e);
    @(posedge clk); #1;
    cmd_opcode = 3'b111; cmd_rd = 2'd0; cmd_imm = 8'hAA;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h32) begin errors++; $display("FAIL bp_first: got v=%b d=%h want 1 32", rsp_valid, rsp_data); end
    for (int i = 0; i < 5; i++) begin
      cmd_imm = 8'($urandom);
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h32 || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL bp_stall%0d: got v=%b d=%h cmd_ready=%b want 1 32 0", i, rsp_valid, rsp_data, cmd_ready);
      end
    end
    cmd_opcode = 3'b001; cmd_rd = 2'd0; cmd_rs1 = 2'd3; cmd_rs2 = 2'd1; rsp_ready = 1'b1;
    model_exec(3'b001, 2'd0, 2'd3, 2'd1, 8'h00, e);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_follow: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_skip_idle: got v=%b cmd_ready=%b want 0 0", rsp_valid, cmd_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== e.d || rsp_rd !== 2'd0) begin
      errors++; $display("FAIL bp_second: got v=%b d=%h rd=%0d want 1 %h 0", rsp_valid, rsp_data, rsp_rd, e.d);
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    exp_t e, o; int lat;
    do_cmd(3'b111, 2'd2, 2'd0, 2'd0, 8'h03, o, lat); model_exec(3'b111, 2'd2, 2'd0, 2'd0, 8'h03, e);
    do_cmd(3'b111, 2'd0, 2'd0, 2'd0, 8'h00, o, lat); model_exec(3'b111, 2'd0, 2'd0, 2'd0, 8'h00, e);
    do_cmd(3'b101, 2'd2, 2'd1, 2'd0, 8'h00, o, lat); model_exec(3'b101, 2'd2, 2'd1, 2'd0, 8'h00, e);
    checks++; if (o.d !== 8'hFF || o.il !== 1'b1 || o.z !== 1'b0) begin
      errors++; $display("FAIL illegal_rsp: got d=%h il=%b z=%b want FF 1 0", o.d, o.il, o.z);
    end
    do_cmd(3'b000, 2'd3, 2'd0, 2'd2, 8'h00, o, lat); model_exec(3'b000, 2'd3, 2'd0, 2'd2, 8'h00, e);
    checks++; if (o.d !== 8'h03 || o.il !== 1'b0) begin errors++; $display("FAIL illegal_no_write: got d=%h il=%b want 03 0", o.d, o.il); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t e;
    int issued = 0, retired = 0, cyc = 0, first = -1, last = -1;
    bit acc, ret;
    cmd_opcode = 3'($urandom_range(0, 3)); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
    cmd_rs2 = 2'($urandom); cmd_imm = 8'($urandom);
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    while (retired < 8 && cyc < 200) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready; ret = rsp_valid && rsp_ready;
      if (ret) begin
        checks++; if (q.size() == 0 || rsp_data !== q[0].d || rsp_rd !== q[0].rd || rsp_zero !== q[0].z) begin
          errors++; $display("FAIL b2b_rsp%0d: got d=%h rd=%0d z=%b", retired, rsp_data, rsp_rd, rsp_zero);
        end
        if (q.size() > 0) void'(q.pop_front());
        retired++;
      end
      if (acc) begin
        model_exec(cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, e);
        q.push_back(e); issued++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      @(posedge clk); #1; cyc++;
      if (acc) begin
        if (issued < 8) begin
          cmd_opcode = ($urandom_range(0, 4) == 4) ? 3'b111 : 3'($urandom_range(0, 3));
          cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom); cmd_rs2 = 2'($urandom); cmd_imm = 8'($urandom);
        end else cmd_valid = 1'b0;
      end
    end
    rsp_ready = 1'b0;
    checks++; if (retired != 8) begin errors++; $display("FAIL b2b_timeout: got %0d retired want 8", retired); end
    checks++; if (last - first != 14) begin errors++; $display("FAIL b2b_throughput: got span %0d want 14", last - first); end
  endtask

  task automatic test_random();
    exp_t q[$]; exp_t e;
    int issued = 0, retired = 0, cyc = 0;
    bit acc, ret;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    while (retired < 40 && cyc < 2000) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready; ret = rsp_valid && rsp_ready;
      if (ret) begin
        checks++; if (q.size() == 0 || rsp_data !== q[0].d || rsp_rd !== q[0].rd ||
                      rsp_zero !== q[0].z || rsp_illegal !== q[0].il) begin
          errors++; $display("FAIL rand_rsp%0d: got d=%h rd=%0d z=%b il=%b", retired, rsp_data, rsp_rd, rsp_zero, rsp_illegal);
        end
        if (q.size() > 0) void'(q.pop_front());
        retired++;
      end
      if (acc) begin
        model_exec(cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, e);
        q.push_back(e); issued++;
      end
      @(posedge clk); #1; cyc++;
      cmd_opcode = 3'($urandom); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
      cmd_rs2 = 2'($urandom); cmd_imm = 8'($urandom);
      cmd_valid = (issued < 40) ? 1'($urandom) : 1'b0;
      rsp_ready = 1'($urandom);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (retired != 40) begin errors++; $display("FAIL rand_timeout: got %0d retired want 40", retired); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    exp_t e, o; int lat, n;
    do_cmd(3'b111, 2'd1, 2'd0, 2'd0, 8'h77, o, lat); model_exec(3'b111, 2'd1, 2'd0, 2'd0, 8'h77, e);
    // Reset while the response is pending must drop rsp_valid before any edge.
    cmd_opcode = 3'b000; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: got %b want 1", rsp_valid); end
    #1 rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_resp_async: got v=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready); end
    @(posedge clk); #1 rst_n = 1'b1; model_clear();
    do_cmd(3'b111, 2'd1, 2'd0, 2'd0, 8'h77, o, lat); model_exec(3'b111, 2'd1, 2'd0, 2'd0, 8'h77, e);
    cmd_opcode = 3'b000; cmd_rd = 2'd1; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    #1 rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 8'h00) begin
      errors++; $display("FAIL rst_exec_async: got v=%b cmd_ready=%b alu_a=%h want 0 1 00", rsp_valid, cmd_ready, alu_a);
    end
    n = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (rsp_valid) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL rst_exec_no_rsp: got %0d valid cycles want 0", n); end
    rst_n = 1'b1; model_clear();
    do_cmd(3'b000, 2'd2, 2'd1, 2'd1, 8'h00, o, lat); model_exec(3'b000, 2'd2, 2'd1, 2'd1, 8'h00, e);
    checks++; if (o.d !== 8'h00 || o.z !== 1'b1 || lat !== 2) begin
      errors++; $display("FAIL rst_exec_cleared: got d=%h z=%b lat=%0d want 00 1 2", o.d, o.z, lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ldi_add();
    test_arith_boundaries();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
